// File: rtl/fft_32p_frame_ctrl_pkg.sv
// fft_32p_pkg: shared sizes, FSM state type and a bus-slice helper for the
// 32-point FFT frame controller.
//   N_POINTS : samples per frame / bins per frame
//   DATA_W   : width of one sample or one bin component
//   IDX_W    : width of a sample/bin index
//   BUS_W    : width of a flattened frame bus (N_POINTS * DATA_W)
package fft_32p_pkg;

  localparam int N_POINTS = 32;
  localparam int DATA_W   = 32;
  localparam int IDX_W    = 5;
  localparam int BUS_W    = N_POINTS * DATA_W;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_UNLOAD = 2'd2
  } state_e;

  // Word idx of a flattened frame bus (word k lives on bits [32k+31:32k]).
  function automatic logic [DATA_W-1:0] bus_word(input logic [BUS_W-1:0] bus,
                                                 input logic [IDX_W-1:0] idx);
    return bus[32'(idx) * DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/fft_32p_frame_ctrl_if.sv
// fft_32p_frame_ctrl_if: sample-in and bin-out valid/ready streams.
//   s_valid/s_ready/s_data          : real input samples into the controller
//   m_valid/m_ready/m_real/m_imag   : output bins from the controller
//   m_index/m_last                  : bin number, high on the final bin
// Modport slave is the controller's view, master is the producer/consumer view.
interface fft_32p_frame_ctrl_if;
  import fft_32p_pkg::*;

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_real;
  logic [DATA_W-1:0] m_imag;
  logic [IDX_W-1:0]  m_index;
  logic              m_last;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_real, m_imag, m_index, m_last
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_real, m_imag, m_index, m_last
  );

endinterface

// File: rtl/fft_32p_sample_buf.sv
// fft_32p_sample_buf: 32 x 32-bit sample register bank.
//   clk, rst_n  : clock, asynchronous active-low reset (clears every word)
//   we          : write enable
//   waddr       : word index written when we=1
//   wdata       : write data
//   rdata_flat  : all words, word k on bits [32k+31:32k]
// Every word is visible at once because the combinational FFT core needs
// the whole frame in parallel, so this cannot be a RAM.
module fft_32p_sample_buf
  import fft_32p_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [BUS_W-1:0]  rdata_flat
);

  generate
    for (genvar gi = 0; gi < N_POINTS; gi++) begin : g_word
      logic [DATA_W-1:0] word_q;
      logic [DATA_W-1:0] word_d;

      always_comb begin
        word_d = word_q;
        if (we && (waddr == IDX_W'(gi))) begin
          word_d = wdata;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          word_q <= '0;
        end else begin
          word_q <= word_d;
        end
      end

      assign rdata_flat[gi*DATA_W +: DATA_W] = word_q;
    end
  endgenerate

endmodule

// File: rtl/fft_32p_frame_ctrl.sv
// fft_32p_frame_ctrl: frames a sample stream for an external combinational
// 32-point FFT core and streams its 32 bins back out.
//   clk, rst_n      : clock, asynchronous active-low reset
//   flush           : synchronous abort of the current frame
//   io (slave)      : s_* sample input stream, m_* bin output stream
//   fft_din         : buffered frame to the core, sample k on [32k+31:32k]
//   fft_dout_real/imag : core results, bin k on [32k+31:32k]
//   busy            : high while settling or unloading
//   frame_done      : one-cycle pulse after bin 31 is accepted
//   frame_cnt       : completed frames, wraps
// Flow: LOAD collects 32 samples, SETTLE waits SETTLE_CYCLES for the core,
// UNLOAD streams the bins, then back to LOAD.
module fft_32p_frame_ctrl
  import fft_32p_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2  // legal range 1..255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  fft_32p_frame_ctrl_if.slave  io,
  output logic [BUS_W-1:0]     fft_din,
  input  logic [BUS_W-1:0]     fft_dout_real,
  input  logic [BUS_W-1:0]     fft_dout_imag,
  output logic                 busy,
  output logic                 frame_done,
  output logic [15:0]          frame_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_POINTS - 1);
  localparam logic [7:0]       SETTLE_END = 8'(SETTLE_CYCLES - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [IDX_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [7:0]        settle_cnt_q, settle_cnt_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              frame_done_q, frame_done_d;

  logic              s_ready;
  logic              m_valid;
  logic              s_hs;
  logic              m_hs;
  logic              buf_we;

  // Handshake flags depend only on registered state plus the peer's valid/ready.
  assign s_ready = (state_q == ST_LOAD);
  assign m_valid = (state_q == ST_UNLOAD);
  assign s_hs    = io.s_valid && s_ready;
  assign m_hs    = m_valid && io.m_ready;

  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    settle_cnt_d = settle_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    buf_we       = 1'b0;

    case (state_q)
      ST_LOAD: begin
        if (s_hs) begin
          buf_we = 1'b1;
          if (wr_cnt_q == LAST_IDX) begin
            wr_cnt_d     = '0;
            settle_cnt_d = '0;
            state_d      = ST_SETTLE;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      ST_SETTLE: begin
        // Counter starts at 0 on entry, so SETTLE lasts exactly SETTLE_CYCLES.
        if (settle_cnt_q == SETTLE_END) begin
          state_d = ST_UNLOAD;
        end else begin
          settle_cnt_d = settle_cnt_q + 8'd1;
        end
      end
      ST_UNLOAD: begin
        if (m_hs) begin
          if (rd_cnt_q == LAST_IDX) begin
            rd_cnt_d     = '0;
            frame_cnt_d  = frame_cnt_q + 16'd1;
            frame_done_d = 1'b1;
            state_d      = ST_LOAD;
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase

    // Flush overrides whatever handshake happened this cycle; the buffer
    // keeps its contents and the frame is not counted.
    if (flush) begin
      state_d      = ST_LOAD;
      wr_cnt_d     = '0;
      rd_cnt_d     = '0;
      settle_cnt_d = '0;
      frame_cnt_d  = frame_cnt_q;
      frame_done_d = 1'b0;
      buf_we       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_LOAD;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      settle_cnt_q <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  fft_32p_sample_buf u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (buf_we),
    .waddr      (wr_cnt_q),
    .wdata      (io.s_data),
    .rdata_flat (fft_din)
  );

  // Bin outputs are pure muxes of rd_cnt and the core; both are frozen while
  // stalled, so the outputs hold without extra registers.
  assign io.s_ready = s_ready;
  assign io.m_valid = m_valid;
  assign io.m_real  = bus_word(fft_dout_real, rd_cnt_q);
  assign io.m_imag  = bus_word(fft_dout_imag, rd_cnt_q);
  assign io.m_index = rd_cnt_q;
  assign io.m_last  = (rd_cnt_q == LAST_IDX);

  assign busy       = (state_q == ST_SETTLE) || (state_q == ST_UNLOAD);
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_fft_32p_frame_ctrl.sv
// tb_fft_32p_frame_ctrl: directed bench for fft_32p_frame_ctrl with a simple
// stand-in core: re[k] = x[0] + (k!=0 ? x[k] : 0), im[k] = x[k] - x[(32-k)%32].
// For an impulse this gives re=1, im=0 on every bin, like a true DFT.
module tb_fft_32p_frame_ctrl;
  import fft_32p_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic [BUS_W-1:0] fft_din;
  logic [BUS_W-1:0] fft_dout_real;
  logic [BUS_W-1:0] fft_dout_imag;
  logic             busy;
  logic             frame_done;
  logic [15:0]      frame_cnt;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_fc = 0;
  logic [31:0] samp [32];
  logic [31:0] prev_s17;

  fft_32p_frame_ctrl_if ifc ();

  fft_32p_frame_ctrl #(.SETTLE_CYCLES(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .io            (ifc.slave),
    .fft_din       (fft_din),
    .fft_dout_real (fft_dout_real),
    .fft_dout_imag (fft_dout_imag),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_cnt     (frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] wd(input logic [BUS_W-1:0] b, input int k);
    return b[k*32 +: 32];
  endfunction

  always_comb begin
    fft_dout_real = '0;
    fft_dout_imag = '0;
    for (int k = 0; k < 32; k++) begin
      fft_dout_real[k*32 +: 32] = wd(fft_din, 0) + ((k != 0) ? wd(fft_din, k) : 32'd0);
      fft_dout_imag[k*32 +: 32] = wd(fft_din, k) - wd(fft_din, (32 - k) % 32);
    end
  end

  function automatic logic [31:0] exp_re(input int k);
    return samp[0] + ((k != 0) ? samp[k] : 32'd0);
  endfunction

  function automatic logic [31:0] exp_im(input int k);
    return samp[k] - samp[(32 - k) % 32];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic send_frame(input int n, input bit gaps);
    int i = 0;
    int t = 0;
    bit v;
    while (i < n) begin
      @(negedge clk);
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      ifc.s_valid = v;
      ifc.s_data  = samp[i];
      if (v && ifc.s_ready) begin
        i++;
      end else if (!ifc.s_ready) begin
        t++;
        if (t > 100) begin
          chk("send_timeout", 64'(i), 64'(n));
          break;
        end
      end
    end
    @(negedge clk);
    ifc.s_valid = 1'b0;
    $display("sent %0d samples (gaps=%0d)", n, gaps);
  endtask

  // pat 0: always ready; pat 1: ready 1,0,0,1 per presented cycle.
  // Stops with m_ready=0 while bin stop_at is presented if stop_at < 32.
  task automatic recv(input int stop_at, input int pat);
    int  bin = 0;
    int  cyc = 0;
    int  t = 0;
    bit  r;
    while (bin < 32) begin
      @(negedge clk);
      if (bin == stop_at && ifc.m_valid) begin
        ifc.m_ready = 1'b0;
        chk("stop_index", 64'(ifc.m_index), 64'(bin));
        return;
      end
      r = (pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      ifc.m_ready = r;
      if (ifc.m_valid) begin
        chk("m_index", 64'(ifc.m_index), 64'(bin));
        chk("m_real", 64'(ifc.m_real), 64'(exp_re(bin)));
        chk("m_imag", 64'(ifc.m_imag), 64'(exp_im(bin)));
        chk("m_last", 64'(ifc.m_last), 64'(bin == 31));
        chk("s_ready_unload", 64'(ifc.s_ready), 64'd0);
        chk("frame_done_early", 64'(frame_done), 64'd0);
        cyc++;
        if (r) begin
          $display("bin %0d re %08h im %08h", bin, ifc.m_real, ifc.m_imag);
          bin++;
        end
      end else begin
        t++;
        if (t > 50) begin
          chk("recv_timeout", 64'(bin), 64'd32);
          return;
        end
      end
    end
    @(negedge clk);
    ifc.m_ready = 1'b0;
    exp_fc++;
    chk("frame_done_pulse", 64'(frame_done), 64'd1);
    chk("frame_cnt", 64'(frame_cnt), 64'(exp_fc));
    chk("m_valid_after", 64'(ifc.m_valid), 64'd0);
    chk("s_ready_after", 64'(ifc.s_ready), 64'd1);
    @(negedge clk);
    chk("frame_done_1cyc", 64'(frame_done), 64'd0);
    $display("frame complete, frame_cnt=%0d", frame_cnt);
  endtask

  initial begin
    ifc.s_valid = 1'b0;
    ifc.s_data  = '0;
    ifc.m_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_s_ready", 64'(ifc.s_ready), 64'd1);
    chk("rst_m_valid", 64'(ifc.m_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_fft_din", 64'(fft_din == '0), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Impulse frame with latency check
    for (int i = 0; i < 32; i++) samp[i] = (i == 0) ? 32'd1 : 32'd0;
    send_frame(32, 1'b0);
    chk("lat_e0_m_valid", 64'(ifc.m_valid), 64'd0);
    chk("lat_e0_busy", 64'(busy), 64'd1);
    chk("lat_e0_s_ready", 64'(ifc.s_ready), 64'd0);
    @(negedge clk);
    chk("lat_e1_m_valid", 64'(ifc.m_valid), 64'd0);
    @(negedge clk);
    chk("lat_e2_m_valid", 64'(ifc.m_valid), 64'd1);
    recv(32, 0);

    // Backpressure 1,0,0,1
    for (int i = 0; i < 32; i++) samp[i] = 32'h1000_0000 + 32'(i * 32'h0101) + 32'(i * i);
    send_frame(32, 1'b0);
    recv(32, 1);

    // Random input gaps
    for (int i = 0; i < 32; i++) samp[i] = $urandom;
    prev_s17 = samp[17];
    send_frame(32, 1'b1);
    recv(32, 0);

    // Flush after 17 samples with a simultaneous handshake that must be dropped
    for (int i = 0; i < 32; i++) samp[i] = 32'hA000_0000 + 32'(i);
    send_frame(17, 1'b0);
    @(negedge clk);
    flush = 1'b1;
    ifc.s_valid = 1'b1;
    ifc.s_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    flush = 1'b0;
    ifc.s_valid = 1'b0;
    chk("flush_slot0_kept", 64'(wd(fft_din, 0)), 64'(samp[0]));
    chk("flush_slot17_kept", 64'(wd(fft_din, 17)), 64'(prev_s17));
    chk("flush_frame_cnt", 64'(frame_cnt), 64'(exp_fc));
    for (int i = 0; i < 32; i++) samp[i] = 32'hB000_0000 + 32'(i * 7);
    send_frame(32, 1'b0);
    recv(32, 0);

    // Flush during UNLOAD: no frame_done, count unchanged
    for (int i = 0; i < 32; i++) samp[i] = 32'hC000_0000 ^ 32'(i << 4);
    send_frame(32, 1'b0);
    recv(5, 0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("uflush_m_valid", 64'(ifc.m_valid), 64'd0);
    chk("uflush_s_ready", 64'(ifc.s_ready), 64'd1);
    chk("uflush_busy", 64'(busy), 64'd0);
    chk("uflush_frame_done", 64'(frame_done), 64'd0);
    chk("uflush_frame_cnt", 64'(frame_cnt), 64'(exp_fc));

    // Reset during UNLOAD at bin 9
    for (int i = 0; i < 32; i++) samp[i] = 32'h0D00_0000 + 32'(i * 3);
    send_frame(32, 1'b0);
    recv(9, 0);
    rst_n = 1'b0;
    #1;
    chk("mrst_m_valid", 64'(ifc.m_valid), 64'd0);
    chk("mrst_s_ready", 64'(ifc.s_ready), 64'd1);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_frame_cnt", 64'(frame_cnt), 64'd0);
    exp_fc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) samp[i] = 32'hE000_0000 + 32'(i * 11);
    send_frame(32, 1'b0);
    recv(32, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_32p_frame_ctrl.md
FFT_32P_FRAME_CTRL -- requirements
Module: fft_32p_frame_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2: cycles the combinational FFT core is given to settle; legal range 1..255.
REQ-002 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 flush  in  1  synchronous abort of the current frame.
REQ-005 s_valid  in  1  input sample valid.
REQ-006 s_ready  out  1  controller can accept a sample.
REQ-007 s_data  in  32  real input sample.
REQ-008 fft_din  out  1024  to core; sample k on bits [32k+31:32k].
REQ-009 fft_dout_real  in  1024  from core; bin k on bits [32k+31:32k].
REQ-010 fft_dout_imag  in  1024  from core; same packing.
REQ-011 m_valid  out  1  output bin valid.
REQ-012 m_ready  in  1  downstream accepts bin.
REQ-013 m_real  out  32  real part of current bin.
REQ-014 m_imag  out  32  imaginary part of current bin.
REQ-015 m_index  out  5  bin number of current output.
REQ-016 m_last  out  1  high with bin 31.
REQ-017 busy  out  1  high in SETTLE or UNLOAD.
REQ-018 frame_done  out  1  one-cycle pulse after bin 31 is accepted.
REQ-019 frame_cnt  out  16  count of completed frames, wraps 0xFFFF->0.

Function
REQ-020 SHALL implement the FSM LOAD -> SETTLE -> UNLOAD -> LOAD.
REQ-021 LOAD: s_ready=1, m_valid=0; on s_valid&s_ready it writes s_data into buffer slot wr_cnt and increments wr_cnt.
REQ-022 The handshake that accepts sample 31 moves the FSM to SETTLE and clears wr_cnt to 0.
REQ-023 SETTLE: s_ready=0, m_valid=0, buffer frozen; lasts exactly SETTLE_CYCLES cycles, then moves to UNLOAD.
REQ-024 UNLOAD: m_valid=1; m_real and m_imag are the core slices selected by rd_cnt; m_index=rd_cnt; m_last=(rd_cnt==31).
REQ-025 UNLOAD: on m_valid&m_ready rd_cnt increments; when m_ready=0, all m_* outputs hold stable.
REQ-026 The handshake that accepts bin 31 moves the FSM to LOAD, clears rd_cnt, increments frame_cnt, and pulses frame_done in the following cycle.
REQ-027 fft_din SHALL always be driven from the buffer registers; the buffer changes only on LOAD handshakes.
REQ-028 flush=1 returns the FSM to LOAD and clears wr_cnt and rd_cnt next cycle from any state; buffer contents are kept; frame_cnt is unchanged; no frame_done is generated.
REQ-029 flush has priority over a simultaneous s or m handshake; that handshake is discarded.
REQ-030 Inputs and outputs never overlap in time: s_ready=0 whenever busy=1.
REQ-031 No arithmetic is performed on data; widths pass through unchanged.

Reset
REQ-032 rst_n low SHALL asynchronously force: state LOAD, wr_cnt=0, rd_cnt=0, buffer all zero, frame_cnt=0, frame_done=0.
REQ-033 Reset output values SHALL be: s_ready=1, m_valid=0, busy=0.
REQ-034 Reset asserted mid-frame SHALL discard the partial frame; the first frame after release starts at slot 0.

Structure
REQ-035 Package fft_32p_pkg SHALL hold N_POINTS=32, DATA_W=32, IDX_W=5, and the FSM state enum.
REQ-036 The 32x32 sample register bank SHALL be a sub-module fft_32p_sample_buf with a write enable, a write index, and a flattened read bus.
REQ-037 The controller SHALL NOT instantiate the FFT core; the top level connects fft_din and fft_dout_* to the core.

Verification
REQ-038 Impulse: samples 1,0,...,0 with m_ready=1 -> 32 bins all real=1, imag=0 (core value), m_index 0..31, m_last only on bin 31, frame_done pulse, frame_cnt=1.
REQ-039 Latency, SETTLE_CYCLES=2: sample 31 accepted at edge E -> m_valid first high after edge E+2.
REQ-040 Backpressure: m_ready toggled 1,0,0,1 -> each bin presented until accepted, none skipped or duplicated, m_* stable while stalled.
REQ-041 Input gaps: s_valid random 50% duty -> exactly 32 samples stored in order; s_ready=0 throughout SETTLE and UNLOAD.
REQ-042 Flush after 17 samples, then a full frame -> outputs match the new frame; frame_cnt increments by 1 only.
REQ-043 rst_n pulsed low during UNLOAD at bin 9 -> m_valid=0 and s_ready=1 immediately; frame_cnt=0.
